io_bus_router: RTL

IO_BUS_ROUTER -- requirements
Module: io_bus_router

---
 rtl/io_bus_pkg.sv | 39 +++
 rtl/io_addr_decoder.sv | 41 ++++
 rtl/io_bus_router.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bus_pkg.sv
// io_bus_pkg -- shared definitions for the io_bus_router slice.
//
// Contents:
//   state_t       router FSM encoding (IDLE, ACCESS, BEAT_WAIT, RELEASE)
//   byte_size_t   transfer size encoding (0 = byte, 1 = half, 2 = word)
//   ERR_DATA_BIT  fill bit for the read data returned on a timeout
//                 (replicated across the data width -> all ones)
//   DEF_*         default slave map: four 256 MB windows starting at 0
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_BEAT_WAIT = 2'd2,
    ST_RELEASE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BSZ_BYTE = 2'd0,
    BSZ_HALF = 2'd1,
    BSZ_WORD = 2'd2
  } byte_size_t;

  // Timeout read data is this bit replicated to DATA_W, so the constant
  // stays all ones whatever data width the router is built with.
  localparam logic ERR_DATA_BIT = 1'b1;

  localparam int DEF_NUM_SLV = 4;
  localparam int DEF_ADDR_W  = 32;

  localparam logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };

  localparam logic [DEF_NUM_SLV*DEF_ADDR_W-1:0] DEF_SLV_MASK = {
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
  };

endpackage

// File: rtl/io_addr_decoder.sv
// io_addr_decoder -- combinational slave address decode.
//
// Picks the lowest slave index i for which (addr & mask[i]) == base[i].
//
// Ports:
//   addr  in  ADDR_W   address to decode
//   sel   out NUM_SLV  one-hot select of the winning slave (0 on a miss)
//   hit   out 1        some slave window matched
//   mask  out ADDR_W   decode mask of the winning slave (0 on a miss)
module io_addr_decoder
  import io_bus_pkg::*;
#(
  parameter int                          NUM_SLV  = DEF_NUM_SLV,
  parameter int                          ADDR_W   = DEF_ADDR_W,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               hit,
  output logic [ADDR_W-1:0]  mask
);

  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // a combinational output unassigned would infer a latch.
    sel  = '0;
    hit  = 1'b0;
    mask = '0;
    // Walk upwards and stop updating after the first match so the lowest
    // index wins when windows overlap.
    for (int i = 0; i < NUM_SLV; i++) begin
      if (!hit && ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        sel[i] = 1'b1;
        hit    = 1'b1;
        mask   = SLV_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/io_bus_router.sv
// io_bus_router -- single-master to NUM_SLV-slave IO bus router.
//
// A request (io_read/io_write) is captured in IDLE and decoded to one slave.
// The router drives the slave strobes until that slave's s_ready, returns the
// slave data on a one-cycle io_ready pulse and, for read bursts, waits for
// read_ready before issuing the next beat at addr + DATA_W/8 on the same
// slave. Unmapped addresses complete at once with io_err. After the last beat
// the router parks in RELEASE until the master drops both request lines.
//
// Optional feature (macro IO_ROUTER_TIMEOUT_EN): a slave that does not answer
// within TIMEOUT_CYC cycles of strobe gets an error completion with all-ones
// data, and any remaining burst beats are abandoned. Without the macro the
// router waits forever and carries no timeout counter.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   io_addr/io_read/io_write      master request (read+write counts as write)
//   burst, burst_size             read burst of burst_size+1 beats
//   read_ready                    master accepted the current burst beat
//   io_wdata, io_byte_size        write data and transfer size
//   io_rdata, io_ready, io_err    completion data, pulse and error flag
//   s_sel, s_addr, s_read,        slave select (one-hot), window offset,
//   s_write, s_wdata, s_byte_size strobes and write payload
//   s_rdata, s_ready              per-slave read data and ready, packed
module io_bus_router
  import io_bus_pkg::*;
#(
  parameter int                        NUM_SLV     = 4,
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = DEF_SLV_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = DEF_SLV_MASK,
  parameter int                        TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  // master side
  input  logic [ADDR_W-1:0]         io_addr,
  input  logic                      io_read,
  input  logic                      io_write,
  input  logic                      burst,
  input  logic [2:0]                burst_size,
  input  logic                      read_ready,
  input  logic [DATA_W-1:0]         io_wdata,
  input  logic [1:0]                io_byte_size,
  output logic [DATA_W-1:0]         io_rdata,
  output logic                      io_ready,
  output logic                      io_err,
  // slave side
  output logic [NUM_SLV-1:0]        s_sel,
  output logic [ADDR_W-1:0]         s_addr,
  output logic                      s_read,
  output logic                      s_write,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [1:0]                s_byte_size,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ready
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  // Registered state. Every output is driven straight from a flop.
  state_t              state_q,   state_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;     // full address of current beat
  logic [ADDR_W-1:0]   mask_q,    mask_d;     // window mask of the locked slave
  logic [3:0]          beats_q,   beats_d;    // beats still to complete
  logic                write_q,   write_d;
  logic [NUM_SLV-1:0]  sel_q,     sel_d;
  logic [ADDR_W-1:0]   s_addr_q,  s_addr_d;
  logic                s_read_q,  s_read_d;
  logic                s_write_q, s_write_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [1:0]          s_bsz_q,   s_bsz_d;
  logic [DATA_W-1:0]   rdata_q,   rdata_d;
  logic                ready_q,   ready_d;
  logic                err_q,     err_d;

  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_hit;
  logic [ADDR_W-1:0]   dec_mask;
  logic [DATA_W-1:0]   rdata_sel;
  logic [ADDR_W-1:0]   next_addr;
  logic                slv_ready;

`ifdef IO_ROUTER_TIMEOUT_EN
  localparam int             TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  // The timeout parameter stays on the interface so both builds share one
  // instantiation; it has no effect here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  io_addr_decoder #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decoder (
    .addr (io_addr),
    .sel  (dec_sel),
    .hit  (dec_hit),
    .mask (dec_mask)
  );

  // One-hot AND-OR mux over the slave read buses; only the locked slave
  // contributes, so unselected slaves cannot disturb the data either.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) rdata_sel = rdata_sel | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign slv_ready = |(s_ready & sel_q);
  // Wraps modulo 2^ADDR_W by construction.
  assign next_addr = addr_q + STRIDE;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    beats_d   = beats_q;
    write_d   = write_q;
    sel_d     = sel_q;
    s_addr_d  = s_addr_q;
    s_read_d  = s_read_q;
    s_write_d = s_write_q;
    s_wdata_d = s_wdata_q;
    s_bsz_d   = s_bsz_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef IO_ROUTER_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (io_read || io_write) begin
          addr_d    = io_addr;
          write_d   = io_write;
          s_wdata_d = io_wdata;
          s_bsz_d   = io_byte_size;
          // Only reads burst; a write (or read+write) is a single beat.
          beats_d   = (burst && !io_write) ? ({1'b0, burst_size} + 4'd1) : 4'd1;
          if (dec_hit) begin
            sel_d     = dec_sel;
            mask_d    = dec_mask;
            s_addr_d  = io_addr & ~dec_mask;
            s_read_d  = !io_write;
            s_write_d = io_write;
`ifdef IO_ROUTER_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
            state_d   = ST_ACCESS;
          end else begin
            // Unmapped: complete with an error right away, no strobes.
            sel_d   = '0;
            beats_d = '0;
            rdata_d = '0;
            ready_d = 1'b1;
            err_d   = 1'b1;
            state_d = ST_RELEASE;
          end
        end
      end

      ST_ACCESS: begin
        if (slv_ready) begin
          rdata_d   = rdata_sel;
          ready_d   = 1'b1;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          beats_d   = beats_q - 4'd1;
          if (beats_q > 4'd1) begin
            state_d = ST_BEAT_WAIT;
          end else begin
            sel_d   = '0;
            state_d = ST_RELEASE;
          end
`ifdef IO_ROUTER_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          // Slave never answered: fail this beat and drop the rest of the burst.
          rdata_d   = {DATA_W{ERR_DATA_BIT}};
          ready_d   = 1'b1;
          err_d     = 1'b1;
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
          sel_d     = '0;
          beats_d   = '0;
          state_d   = ST_RELEASE;
        end else begin
          to_cnt_d  = to_cnt_q + TO_W'(1);
`endif
        end
      end

      ST_BEAT_WAIT: begin
        if (read_ready) begin
          // Later beats stay on the slave locked at the first beat, even if
          // the address walks out of its window.
          addr_d    = next_addr;
          s_addr_d  = next_addr & ~mask_q;
          s_read_d  = !write_q;
          s_write_d = write_q;
`ifdef IO_ROUTER_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          state_d   = ST_ACCESS;
        end
      end

      ST_RELEASE: begin
        // A request held high after completion must not start a new access.
        if (!io_read && !io_write) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      mask_q    <= '0;
      beats_q   <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      s_addr_q  <= '0;
      s_read_q  <= 1'b0;
      s_write_q <= 1'b0;
      s_wdata_q <= '0;
      s_bsz_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef IO_ROUTER_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      beats_q   <= beats_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      s_addr_q  <= s_addr_d;
      s_read_q  <= s_read_d;
      s_write_q <= s_write_d;
      s_wdata_q <= s_wdata_d;
      s_bsz_q   <= s_bsz_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef IO_ROUTER_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign io_rdata    = rdata_q;
  assign io_ready    = ready_q;
  assign io_err      = err_q;
  assign s_sel       = sel_q;
  assign s_addr      = s_addr_q;
  assign s_read      = s_read_q;
  assign s_write     = s_write_q;
  assign s_wdata     = s_wdata_q;
  assign s_byte_size = s_bsz_q;

endmodule
